// File: rtl/sar_seq_adc_pkg.sv
// Shared types and constants for the sequencing SAR ADC controller.
package adc_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_STORE
  } adc_state_e;

  // Number of prescaler ticks the sample-and-hold stays in track mode
  localparam int SAMPLE_TICKS = 2;

  // Channel select width; a single-channel mux still needs one bit
  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/sar_seq_adc_if.sv
// Control, analog front-end, status and result-FIFO signals of the ADC.
interface sar_seq_adc_if #(
  parameter int ADC_WIDTH = 12,
  parameter int NUM_CH    = 4
);
  localparam int CH_W = adc_pkg::ch_w(NUM_CH);

  logic                      enable;
  logic                      start;
  logic                      auto_mode;
  logic [NUM_CH-1:0]         ch_mask;
  logic                      comparator;
  logic [ADC_WIDTH-1:0]      dac;
  logic [CH_W-1:0]           mux_sel;
  logic                      sample_and_hold;
  logic                      busy;
  logic                      rd_en;
  logic [CH_W+ADC_WIDTH-1:0] rd_data;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      overflow;
  logic                      irq_en;
  logic                      irq_clr;
  logic                      irq;

  modport master (
    output enable, start, auto_mode, ch_mask, comparator, rd_en, irq_en, irq_clr,
    input  dac, mux_sel, sample_and_hold, busy, rd_data, fifo_empty, fifo_full,
           overflow, irq
  );

  modport slave (
    input  enable, start, auto_mode, ch_mask, comparator, rd_en, irq_en, irq_clr,
    output dac, mux_sel, sample_and_hold, busy, rd_data, fifo_empty, fifo_full,
           overflow, irq
  );

endinterface

// File: rtl/sar_seq_adc_fifo.sv
// Result FIFO: synchronous write/pop, head word presented combinationally.
module adc_result_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Flags, accepted operations and next pointers; a push at full is taken only alongside a pop
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage array; contents are not cleared so an empty head keeps its last value
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/sar_seq_adc.sv
// Multi-channel SAR ADC sequencer: scans masked channels, converts, queues results.
module sar_seq_adc
  import adc_pkg::*;
#(
  parameter int ADC_WIDTH  = 12,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4
) (
  input logic          sys_clk,
  input logic          reset,
  sar_seq_adc_if.slave bus
);
  localparam int CH_W   = ch_w(NUM_CH);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(ADC_WIDTH);
  localparam int SAMP_W = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam int DATA_W = CH_W + ADC_WIDTH;

  adc_state_e           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SAMP_W-1:0]    samp_q, samp_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [ADC_WIDTH-1:0] dac_q, dac_d;
  logic [CH_W-1:0]      mux_q, mux_d;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic                 irq_pending_q, irq_pending_d;
  logic                 overflow_q, overflow_d;
  logic                 tick, push, scan_done, drop, has_next, mask_nz;
  logic [CH_W-1:0]      first_ch, next_ch;
  logic [DATA_W-1:0]    fifo_rd_data;
  logic                 fifo_empty, fifo_full;

  // Channel search: lowest live mask bit, and next latched mask bit above the current channel
  always_comb begin
    mask_nz  = (bus.ch_mask != '0);
    first_ch = '0;
    next_ch  = mux_q;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) first_ch = CH_W'(i);
      if (mask_q[i] && (i > int'(mux_q))) begin
        has_next = 1'b1;
        next_ch  = CH_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping enable aborts from any state
  always_comb begin
    tick    = (div_q == DIV_W'(CLK_DIV - 1));
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (bus.start && mask_nz) state_d = ST_SAMPLE;
        ST_SAMPLE:  if (tick && samp_q == SAMP_W'(SAMPLE_TICKS - 1)) state_d = ST_CONVERT;
        ST_CONVERT: if (tick && bit_q == '0) state_d = ST_STORE;
        ST_STORE:   state_d = (has_next || (bus.auto_mode && mask_nz)) ? ST_SAMPLE : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: prescaler restarts on every SAMPLE entry so each channel has identical latency
  always_comb begin
    div_d         = (state_q == ST_IDLE || state_q == ST_STORE || tick) ? '0 : div_q + 1'b1;
    samp_d        = samp_q;
    bit_d         = bit_q;
    dac_d         = dac_q;
    mux_d         = mux_q;
    mask_d        = mask_q;
    push          = 1'b0;
    scan_done     = 1'b0;
    if (!bus.enable) begin
      dac_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dac_d = '0;
          if (bus.start && mask_nz) begin
            mask_d = bus.ch_mask;
            mux_d  = first_ch;
            samp_d = '0;
          end
        end
        ST_SAMPLE: begin
          if (tick) begin
            if (samp_q == SAMP_W'(SAMPLE_TICKS - 1)) begin
              dac_d = {1'b1, {(ADC_WIDTH - 1){1'b0}}};
              bit_d = BIT_W'(ADC_WIDTH - 1);
            end else begin
              samp_d = samp_q + 1'b1;
            end
          end
        end
        ST_CONVERT: begin
          if (tick) begin
            dac_d[bit_q] = bus.comparator;
            if (bit_q != '0) begin
              dac_d[bit_q - 1'b1] = 1'b1;
              bit_d = bit_q - 1'b1;
            end
          end
        end
        ST_STORE: begin
          push   = 1'b1;
          dac_d  = '0;
          samp_d = '0;
          if (has_next) begin
            mux_d = next_ch;
          end else begin
            scan_done = 1'b1;
            if (bus.auto_mode && mask_nz) begin
              mask_d = bus.ch_mask;
              mux_d  = first_ch;
            end
          end
        end
        default: dac_d = '0;
      endcase
    end
    drop          = push && fifo_full && !bus.rd_en;
    irq_pending_d = (irq_pending_q && !bus.irq_clr) || scan_done;
    overflow_d    = (overflow_q && !bus.irq_clr) || drop;
  end

  // Datapath registers
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      samp_q        <= '0;
      bit_q         <= '0;
      dac_q         <= '0;
      mux_q         <= '0;
      mask_q        <= '0;
      irq_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      samp_q        <= samp_d;
      bit_q         <= bit_d;
      dac_q         <= dac_d;
      mux_q         <= mux_d;
      mask_q        <= mask_d;
      irq_pending_q <= irq_pending_d;
      overflow_q    <= overflow_d;
    end
  end

  adc_result_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (reset),
    .push    (push),
    .pop     (bus.rd_en),
    .wr_data ({mux_q, dac_q}),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Output decode from state and registers
  always_comb begin
    bus.busy            = (state_q != ST_IDLE);
    bus.sample_and_hold = (state_q == ST_SAMPLE);
    bus.dac             = dac_q;
    bus.mux_sel         = mux_q;
    bus.irq             = irq_pending_q && bus.irq_en;
    bus.overflow        = overflow_q;
    bus.rd_data         = fifo_rd_data;
    bus.fifo_empty      = fifo_empty;
    bus.fifo_full       = fifo_full;
  end

endmodule

// File: tb/tb_sar_seq_adc.sv
// Self-checking bench for sar_seq_adc against a queue-based scan/FIFO model.
module tb_sar_seq_adc;
  localparam int ADC_W = 12;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;
  localparam int CHW   = 2;
  localparam int LAT   = (2 + ADC_W) * DIV + 1;
  localparam int LIMIT = 3000;

  logic                  sys_clk = 1'b0;
  logic                  reset   = 1'b1;
  logic [ADC_W-1:0]      vin [NCH];
  logic [CHW+ADC_W-1:0]  exp_q [$];
  logic                  exp_ovf;
  int                    checks = 0;
  int                    fails  = 0;
  int                    cyc;

  sar_seq_adc_if #(.ADC_WIDTH(ADC_W), .NUM_CH(NCH)) bus ();

  sar_seq_adc #(
    .ADC_WIDTH  (ADC_W),
    .NUM_CH     (NCH),
    .FIFO_DEPTH (DEPTH),
    .CLK_DIV    (DIV)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  assign bus.comparator = (vin[bus.mux_sel] >= bus.dac);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void modelScan(input logic [NCH-1:0] mask);
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({CHW'(ch), vin[ch]});
        else exp_ovf = 1'b1;
      end
    end
  endfunction

  task automatic pulseStart(input logic [NCH-1:0] mask, input bit scramble);
    bus.ch_mask = mask;
    bus.start   = 1'b1;
    @(negedge sys_clk);
    bus.start   = 1'b0;
    if (scramble) bus.ch_mask = NCH'($urandom);
  endtask

  task automatic waitIrq(output int n);
    n = 0;
    while (bus.irq !== 1'b1 && n < LIMIT) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic pulseIrqClr();
    bus.irq_clr = 1'b1;
    @(negedge sys_clk);
    bus.irq_clr = 1'b0;
    exp_ovf     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] mask, input string tag);
    int n;
    pulseStart(mask, 1'b1);
    waitIrq(n);
    checkOutput({tag, "_latency"}, n, $countones(mask) * LAT);
    checkOutput({tag, "_busy_done"}, bus.busy, 1'b0);
    modelScan(mask);
    pulseIrqClr();
    checkOutput({tag, "_irq_clr"}, bus.irq, 1'b0);
  endtask

  task automatic popCheck(input string tag);
    checkOutput({tag, "_rd_data"}, bus.rd_data, exp_q[0]);
    void'(exp_q.pop_front());
    bus.rd_en = 1'b1;
    @(negedge sys_clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) popCheck(tag);
    checkOutput({tag, "_empty"}, bus.fifo_empty, 1'b1);
  endtask

  initial begin
    bus.enable = 1'b0; bus.start = 1'b0; bus.auto_mode = 1'b0; bus.ch_mask = '0;
    bus.rd_en = 1'b0; bus.irq_en = 1'b1; bus.irq_clr = 1'b0;
    for (int ch = 0; ch < NCH; ch++) vin[ch] = '0;
    exp_ovf = 1'b0;
    repeat (3) @(negedge sys_clk);

    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_dac", bus.dac, '0);
    checkOutput("rst_mux", bus.mux_sel, '0);
    checkOutput("rst_sh", bus.sample_and_hold, 1'b0);
    checkOutput("rst_empty", bus.fifo_empty, 1'b1);
    checkOutput("rst_full", bus.fifo_full, 1'b0);
    checkOutput("rst_ovf", bus.overflow, 1'b0);
    checkOutput("rst_irq", bus.irq, 1'b0);
    reset = 1'b0;
    bus.enable = 1'b1;
    @(negedge sys_clk);

    vin[0] = 12'hA52;
    applyStimulus(4'b0001, "single");
    drain("single");

    vin[1] = 12'h123; vin[3] = 12'hFFF;
    applyStimulus(4'b1010, "pair");
    drain("pair");

    for (int n = 0; n < 6; n++) begin
      for (int ch = 0; ch < NCH; ch++) vin[ch] = ADC_W'($urandom_range(0, 4095));
      applyStimulus(NCH'($urandom_range(1, 15)), "rand");
      drain("rand");
    end

    vin = '{12'h000, 12'hFFF, 12'h800, 12'h7FF};
    applyStimulus(4'b1111, "edges");
    drain("edges");

    bus.irq_en = 1'b0;
    pulseStart(4'b0100, 1'b0);
    repeat (LAT) @(negedge sys_clk);
    checkOutput("irq_gated", bus.irq, 1'b0);
    bus.irq_en = 1'b1;
    #1;
    checkOutput("irq_ungated", bus.irq, 1'b1);
    modelScan(4'b0100);
    pulseIrqClr();
    drain("gated");

    pulseStart(4'b0000, 1'b0);
    checkOutput("mask0_busy", bus.busy, 1'b0);
    repeat (3) @(negedge sys_clk);
    checkOutput("mask0_busy_later", bus.busy, 1'b0);

    vin[0] = ADC_W'($urandom); vin[1] = ADC_W'($urandom);
    pulseStart(4'b0001, 1'b0);
    repeat (19) @(negedge sys_clk);
    bus.ch_mask = 4'b0010; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    waitIrq(cyc);
    checkOutput("busy_start_latency", cyc + 20, LAT);
    modelScan(4'b0001);
    pulseIrqClr();
    repeat (5) @(negedge sys_clk);
    checkOutput("busy_start_idle", bus.busy, 1'b0);
    drain("busy_start");

    vin[2] = ADC_W'($urandom);
    pulseStart(4'b0100, 1'b0);
    checkOutput("sh_track", bus.sample_and_hold, 1'b1);
    checkOutput("mux_ch2", bus.mux_sel, 2'd2);
    repeat (33) @(negedge sys_clk);
    checkOutput("sh_hold", bus.sample_and_hold, 1'b0);
    checkOutput("dac_trial_bit5", bus.dac, (vin[2] & 12'hFC0) | 12'h020);
    bus.enable = 1'b0;
    @(negedge sys_clk);
    checkOutput("drop_busy", bus.busy, 1'b0);
    checkOutput("drop_dac", bus.dac, '0);
    checkOutput("drop_sh", bus.sample_and_hold, 1'b0);
    checkOutput("drop_empty", bus.fifo_empty, 1'b1);
    bus.enable = 1'b1;
    @(negedge sys_clk);
    applyStimulus(4'b0100, "after_drop");
    drain("after_drop");

    for (int ch = 0; ch < NCH; ch++) vin[ch] = ADC_W'($urandom);
    bus.auto_mode = 1'b1;
    pulseStart(4'b1111, 1'b0);
    cyc = 0;
    while (bus.overflow !== 1'b1 && cyc < LIMIT) begin
      @(negedge sys_clk);
      cyc++;
    end
    checkOutput("auto_ovf_latency", cyc, 9 * LAT);
    bus.enable = 1'b0;
    @(negedge sys_clk);
    bus.enable = 1'b1; bus.auto_mode = 1'b0;
    modelScan(4'b1111); modelScan(4'b1111); modelScan(4'b0001);
    checkOutput("auto_full", bus.fifo_full, 1'b1);
    checkOutput("auto_ovf", bus.overflow, exp_ovf);
    checkOutput("auto_irq", bus.irq, 1'b1);
    pulseIrqClr();
    checkOutput("auto_ovf_clr", bus.overflow, exp_ovf);
    checkOutput("auto_irq_clr", bus.irq, 1'b0);
    drain("auto");

    for (int ch = 0; ch < NCH; ch++) vin[ch] = ADC_W'($urandom);
    applyStimulus(4'b1111, "fill_a");
    applyStimulus(4'b1111, "fill_b");
    checkOutput("fill_full", bus.fifo_full, 1'b1);
    vin[0] = ADC_W'($urandom);
    pulseStart(4'b0001, 1'b0);
    repeat (56) @(negedge sys_clk);
    checkOutput("pp_head", bus.rd_data, exp_q[0]);
    void'(exp_q.pop_front());
    bus.rd_en = 1'b1;
    @(negedge sys_clk);
    bus.rd_en = 1'b0;
    modelScan(4'b0001);
    checkOutput("pp_irq", bus.irq, 1'b1);
    checkOutput("pp_full", bus.fifo_full, 1'b1);
    checkOutput("pp_ovf", bus.overflow, 1'b0);
    pulseIrqClr();
    drain("pushpop");

    pulseStart(4'b0001, 1'b0);
    waitIrq(cyc);
    checkOutput("pre_reset_latency", cyc, LAT);
    pulseStart(4'b1111, 1'b0);
    repeat (100) @(negedge sys_clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", bus.busy, 1'b0);
    checkOutput("mid_rst_dac", bus.dac, '0);
    checkOutput("mid_rst_mux", bus.mux_sel, '0);
    checkOutput("mid_rst_sh", bus.sample_and_hold, 1'b0);
    checkOutput("mid_rst_empty", bus.fifo_empty, 1'b1);
    checkOutput("mid_rst_full", bus.fifo_full, 1'b0);
    checkOutput("mid_rst_ovf", bus.overflow, 1'b0);
    checkOutput("mid_rst_irq", bus.irq, 1'b0);
    exp_q.delete();
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sar_seq_adc.md
SAR_SEQ_ADC -- requirements
Module: sar_seq_adc

Interface
REQ-001 Parameter ADC_WIDTH, default 12, SAR resolution in bits (4..16).
REQ-002 Parameter NUM_CH, default 4, analog mux channels (1..16); CH_W = max(1, clog2(NUM_CH)).
REQ-003 Parameter FIFO_DEPTH, default 8, result FIFO entries (power of 2, >=2).
REQ-004 Parameter CLK_DIV, default 4, sys_clk cycles per ADC tick (>=2).
REQ-005 sys_clk  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  block enable; low forces IDLE and aborts any conversion.
REQ-008 start  in  1  single-cycle pulse; begins one scan.
REQ-009 auto_mode  in  1  1 = restart the scan continuously after the last channel.
REQ-010 ch_mask  in  NUM_CH  channels included in the scan.
REQ-011 comparator  in  1  1 = vin >= dac.
REQ-012 dac  out  ADC_WIDTH  SAR trial code.
REQ-013 mux_sel  out  CH_W  selected channel.
REQ-014 sample_and_hold  out  1  1 = track, 0 = hold.
REQ-015 busy  out  1  high outside IDLE.
REQ-016 rd_en  in  1  FIFO pop; ignored when empty.
REQ-017 rd_data  out  CH_W+ADC_WIDTH  {channel, result} at FIFO head; combinational from head.
REQ-018 fifo_empty, fifo_full  out  1 each  FIFO flags.
REQ-019 overflow  out  1  sticky; set when a result is dropped.
REQ-020 irq_en, irq_clr  in  1 each  interrupt enable; clear pulse for irq and overflow.
REQ-021 irq  out  1  sticky scan-done interrupt, gated by irq_en.

Function
REQ-022 The prescaler SHALL generate a one-cycle tick every CLK_DIV cycles; it SHALL reset to 0 when leaving IDLE, so the first tick occurs CLK_DIV cycles after SAMPLE is entered.
REQ-023 States: IDLE, SAMPLE, CONVERT, STORE. IDLE->SAMPLE when start & enable & (ch_mask != 0); otherwise start is ignored.
REQ-024 On entering SAMPLE, mux_sel SHALL take the lowest set ch_mask bit (first channel) or the next set bit above the current one; sample_and_hold = 1 for 2 ticks, then 0 on entry to CONVERT.
REQ-025 CONVERT SHALL take ADC_WIDTH ticks, MSB first: trial bit set in dac; at the next tick the bit is kept iff comparator = 1, and the next lower bit is set.
REQ-026 STORE SHALL last 1 cycle and push {mux_sel, result}; per-channel latency = (2+ADC_WIDTH)*CLK_DIV+1 cycles.
REQ-027 After STORE: if higher masked channels remain -> SAMPLE; else set irq_pending, then -> SAMPLE (first channel) if auto_mode & enable, else -> IDLE.
REQ-028 ch_mask SHALL be sampled once per scan at scan start; changes mid-scan take effect on the next scan.
REQ-029 FIFO full at push without a simultaneous pop: the result is dropped and overflow set; a push and pop in the same cycle when full SHALL both occur, with no overflow.
REQ-030 Pop when empty SHALL have no effect; rd_data is undefined-but-stable (holds the last head value).
REQ-031 irq = irq_pending & irq_en; irq_clr clears irq_pending and overflow; a set in the same cycle as irq_clr wins.
REQ-032 enable low in any state: -> IDLE the next cycle, dac = 0, sample_and_hold = 0, FIFO contents retained, no push of the partial result.
REQ-033 start while busy SHALL be ignored.

Reset
REQ-034 Reset SHALL give: state IDLE, dac 0, mux_sel 0, sample_and_hold 0, busy 0, FIFO empty (fifo_empty 1, fifo_full 0), overflow 0, irq 0, prescaler 0.
REQ-035 Reset SHALL take effect immediately, mid-conversion included; no result is pushed.

Structure
REQ-036 Package adc_pkg SHALL hold the state enum, the 2-tick sample-length constant and the CH_W function.
REQ-037 The FIFO SHALL be a sub-module, adc_result_fifo (parametrised width/depth, sync read/write, full/empty).

Verification
REQ-038 Defaults; comparator modelled as vin >= dac; ch_mask=4'b0001, vin=0xA52, start -> one entry {0,0xA52}, irq after 57 cycles from start.
REQ-039 ch_mask=4'b1010, ch1=0x123, ch3=0xFFF -> entries {1,0x123}, {3,0xFFF} in order; one irq.
REQ-040 auto_mode=1, mask=4'b1111, no pops -> 8 entries, then fifo_full, overflow=1; first 8 entries intact; irq_clr clears overflow.
REQ-041 enable dropped at CONVERT bit 5 -> IDLE next cycle, dac=0, no new entry; a later start converts correctly.
REQ-042 ch_mask=0 + start -> busy stays 0; start during busy -> ignored; push and pop in the same cycle at full -> count unchanged, overflow 0.
REQ-043 Reset asserted mid-scan -> all outputs at reset values in the same cycle, FIFO empty.
